aes_inv_key_sched: RTL and testbench

Iterative AES-128 inverse key scheduler for the decryption datapath. It is loaded with the final (round-10) round key and steps the key schedule backwards, one round per accepted transfer. Round keys are emitted in decryption order, 10 down to 0, over a valid/ready stream. It is the reverse-direction companion of the per-round forward key-expansion stage.

---
 rtl/aes_pkg.sv | 64 ++++++
 rtl/aes_sbox4.sv | 16 +
 rtl/aes_inv_key_sched.sv | 128 ++++++++++++
 tb/tb_aes_inv_key_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key/word types, S-box and Rcon helpers, scheduler FSM states.
// StFwd exists only when AES_INV_KEY_SCHED_FWD_PRECOMPUTE_EN is defined.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key_t;

    typedef enum logic [1:0] {
        StIdle,
        StEmit
`ifdef AES_INV_KEY_SCHED_FWD_PRECOMPUTE_EN
        , StFwd
`endif
    } state_t;

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SboxTable[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic word_t rotWord(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic word_t rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return {c, 24'h000000};
    endfunction

endpackage

// File: rtl/aes_sbox4.sv
// Combinational SubWord: four parallel byte S-box lookups.
module aes_sbox4
    import aes_pkg::*;
(
    input  logic [31:0] wordIn,
    output logic [31:0] wordOut
);

    always_comb begin
        wordOut = '0;
        for (int i = 0; i < 4; i++) begin
            wordOut[8*i +: 8] = sbox(wordIn[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key scheduler; emits round keys 10..0 over valid/ready.
// Define AES_INV_KEY_SCHED_FWD_PRECOMPUTE_EN to load the cipher key and expand forward first.
module aes_inv_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         done
);

    state_t stateQ, stateD;
    key_t   rkQ, rkD;
    logic [3:0] roundQ, roundD;
    logic   doneQ, doneD;

    word_t w0, w1, w2, w3;
    word_t p0, p1, p2, p3;
    word_t sboxIn, sboxOut;
    key_t  invKey;

    assign w0 = rkQ[127:96];
    assign w1 = rkQ[95:64];
    assign w2 = rkQ[63:32];
    assign w3 = rkQ[31:0];

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign p0 = w0 ^ sboxOut ^ rcon(roundQ);
    assign invKey = {p0, p1, p2, p3};

`ifdef AES_INV_KEY_SCHED_FWD_PRECOMPUTE_EN
    word_t n0, n1, n2, n3;
    key_t  fwdKey;

    assign n0 = w0 ^ sboxOut ^ rcon(roundQ + 4'd1);
    assign n1 = n0 ^ w1;
    assign n2 = n1 ^ w2;
    assign n3 = n2 ^ w3;
    assign fwdKey = {n0, n1, n2, n3};

    always_comb begin
        sboxIn = rotWord(p3);
        if (stateQ == StFwd) begin
            sboxIn = rotWord(w3);
        end
    end
`else
    assign sboxIn = rotWord(p3);
`endif

    aes_sbox4 uSbox (
        .wordIn  (sboxIn),
        .wordOut (sboxOut)
    );

    always_comb begin
        stateD = stateQ;
        rkD    = rkQ;
        roundD = roundQ;
        doneD  = 1'b0;
        case (stateQ)
            StIdle: begin
                // doneQ high means the last key was accepted just now; a start here is dropped.
                if (start && !doneQ) begin
                    rkD = key_in;
`ifdef AES_INV_KEY_SCHED_FWD_PRECOMPUTE_EN
                    stateD = StFwd;
                    roundD = 4'd0;
`else
                    stateD = StEmit;
                    roundD = 4'(NUM_ROUNDS);
`endif
                end
            end
            StEmit: begin
                if (rk_ready) begin
                    if (roundQ == 4'd0) begin
                        stateD = StIdle;
                        doneD  = 1'b1;
                    end else begin
                        rkD    = invKey;
                        roundD = roundQ - 4'd1;
                    end
                end
            end
`ifdef AES_INV_KEY_SCHED_FWD_PRECOMPUTE_EN
            StFwd: begin
                rkD    = fwdKey;
                roundD = roundQ + 4'd1;
                if (roundQ == 4'(NUM_ROUNDS - 1)) begin
                    stateD = StEmit;
                end
            end
`endif
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
            rkQ    <= '0;
            roundQ <= '0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            rkQ    <= rkD;
            roundQ <= roundD;
            doneQ  <= doneD;
        end
    end

    // All outputs come straight from registers; rk_ready only steers next state.
    assign busy     = (stateQ != StIdle);
    assign rk_valid = (stateQ == StEmit);
    assign rk_out   = rkQ;
    assign rk_round = roundQ;
    assign done     = doneQ;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched using the FIPS-197 AES-128 key schedule.
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         done;

    aes_inv_key_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   r;
        logic [127:0] k;
    } exp_t;

    exp_t         sbQ[$];
    logic [127:0] expKeys [0:10];
    int           nChecks = 0;
    int           nErrors = 0;
    int           doneSeen = 0;
    int           doneWant = 0;
    bit           randReady = 0;

`ifdef AES_INV_KEY_SCHED_FWD_PRECOMPUTE_EN
    localparam int Lat = 11;
    localparam bit FwdMode = 1'b1;
`else
    localparam int Lat = 1;
    localparam bit FwdMode = 1'b0;
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushSeq();
        exp_t e;
        for (int r = 10; r >= 0; r--) begin
            e.r = 4'(r);
            e.k = expKeys[r];
            sbQ.push_back(e);
        end
    endtask

    // Called with start already high; it is sampled at the next rising edge.
    task automatic finishStart();
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < Lat; i++) begin
            chk("fwd_busy_novalid", {126'd0, busy, rk_valid}, 128'd2);
            @(negedge clk);
        end
        chk("first_valid", {123'd0, rk_valid, rk_round}, {123'd0, 1'b1, 4'd10});
        chk("first_key", rk_out, expKeys[10]);
    endtask

    task automatic startSeq();
        pushSeq();
        @(negedge clk);
        start = 1'b1;
        finishStart();
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", {127'd0, done}, 128'd1);
        doneWant++;
    endtask

    task automatic waitRound(input logic [3:0] r);
        int n;
        n = 0;
        while (!(rk_valid === 1'b1 && rk_round === r) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("round_timeout", {124'd0, rk_round}, {124'd0, r});
    endtask

    // Ready driver
    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rk_ready = randReady ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every transfer, checks stall stability and done timing.
    initial begin
        bit           stallPend;
        bit           doneExpect;
        logic [127:0] heldK;
        logic [3:0]   heldR;
        exp_t         e;
        stallPend  = 0;
        doneExpect = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                stallPend  = 0;
                doneExpect = 0;
            end else begin
                if (stallPend) begin
                    chk("stall_hold", {rk_valid, rk_round, rk_out}, {1'b1, heldR, heldK});
                    stallPend = 0;
                end
                if (done === 1'b1 || doneExpect) begin
                    chk("done_pulse", {127'd0, done}, {127'd0, doneExpect});
                    if (done === 1'b1) doneSeen++;
                end
                doneExpect = 0;
                if (rk_valid === 1'b1 && rk_ready === 1'b1) begin
                    if (sbQ.size() == 0) begin
                        chk("unexpected_key", {124'd0, rk_round}, 128'hffff);
                    end else begin
                        e = sbQ.pop_front();
                        chk("rk_round", {124'd0, rk_round}, {124'd0, e.r});
                        chk("rk_out", rk_out, e.k);
                        if (e.r == 4'd0) doneExpect = 1;
                    end
                end else if (rk_valid === 1'b1) begin
                    stallPend = 1;
                    heldK     = rk_out;
                    heldR     = rk_round;
                end
            end
        end
    end

    initial begin
        expKeys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        expKeys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        expKeys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        expKeys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        expKeys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        expKeys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        expKeys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        expKeys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        expKeys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        expKeys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        expKeys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst    = 1'b1;
        start  = 1'b0;
        key_in = FwdMode ? expKeys[0] : expKeys[10];
        repeat (3) @(negedge clk);
        chk("reset_flags", {125'd0, busy, rk_valid, done}, 128'd0);
        chk("reset_rk_out", rk_out, 128'd0);
        chk("reset_rk_round", {124'd0, rk_round}, 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_start", {126'd0, busy, rk_valid}, 128'd0);

        // Full-rate sequence
        startSeq();
        waitDone();

        // Backpressure
        randReady = 1;
        repeat (3) @(negedge clk);
        startSeq();
        waitDone();
        randReady = 0;
        repeat (3) @(negedge clk);

        // Start pulsed mid-sequence is ignored
        startSeq();
        waitRound(4'd5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone();
        repeat (3) @(negedge clk);

        // Reset mid-sequence aborts without done
        startSeq();
        waitRound(4'd6);
        rst = 1'b1;
        #1;
        chk("abort_flags", {125'd0, busy, rk_valid, done}, 128'd0);
        chk("abort_rk_out", rk_out, 128'd0);
        chk("abort_rk_round", {124'd0, rk_round}, 128'd0);
        sbQ.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_no_done", 128'(doneSeen), 128'(doneWant));
        startSeq();
        waitDone();

        // Start during the done cycle is dropped; held one more cycle it is taken
        start = 1'b1;
        pushSeq();
        @(negedge clk);
        chk("start_in_done_ignored", {126'd0, busy, rk_valid}, 128'd0);
        finishStart();
        waitDone();

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 128'(sbQ.size()), 128'd0);
        chk("done_count", 128'(doneSeen), 128'(doneWant));
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
